// File: rtl/iter_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : iter_div
// Brief    : Iterative restoring divider, one quotient bit per cycle, signed
//            or unsigned, with valid/ready request and result handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dsr;
    logic [WIDTH-1:0]   r_orig;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_nxt;

    // Negation in WIDTH bits maps the most-negative value onto its correct
    // unsigned magnitude, so no extra intermediate bit is needed here.
    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dsr_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dsr_mag = w_dsr_neg ? (~divisor + 1'b1) : divisor;

    // The partial remainder is shifted into WIDTH+1 bits before the trial compare.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dsr});
    assign w_rem_nxt = w_ge ? (w_rem_sh - {1'b0, r_dsr}) : w_rem_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_quo         <= '0;
            r_rem         <= '0;
            r_dsr         <= '0;
            r_orig        <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dbz         <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_quo      <= w_dvd_mag;
                        r_rem      <= '0;
                        r_dsr      <= w_dsr_mag;
                        r_orig     <= dividend;
                        r_neg_q    <= w_dvd_neg ^ w_dsr_neg;
                        r_neg_r    <= w_dvd_neg;
                        r_dbz      <= (divisor == '0);
                        r_cnt      <= c_CNT_INIT;
                        r_in_ready <= 1'b0;
                        r_state    <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_rem <= w_rem_nxt[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= c_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_FIX: begin
                    if (r_dbz) begin
                        r_quotient  <= '1;
                        r_remainder <= r_orig;
                    end else begin
                        r_quotient  <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                        r_remainder <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                    end
                    r_div_by_zero <= r_dbz;
                    r_out_valid   <= 1'b1;
                    r_state       <= c_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_iter_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_iter_div
// Brief    : Self-checking bench for iter_div (WIDTH=32): random requests
//            against an arithmetic reference plus directed literal cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_div;

    localparam int c_W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           is_signed = 1'b0;
    logic [c_W-1:0] dividend = '0;
    logic [c_W-1:0] divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           div_by_zero;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    iter_div #(.WIDTH(c_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the two special cases layered on top.
    task automatic model(input bit s, input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         output logic [c_W-1:0] q, output logic [c_W-1:0] r, output logic z);
        longint sa, sb;
        z = 1'b0;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = c_W'(sa / sb);
            r = c_W'(sa % sb);
        end
    endtask

    // Cycle-by-cycle checker: one request outstanding at most.
    bit             m_busy = 1'b0;
    int             m_acc;
    logic [c_W-1:0] m_q, m_r;
    logic           m_z;

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            chk("in_ready_idle", 64'(in_ready), 64'd1);
            chk("out_valid_idle", 64'(out_valid), 64'd0);
            if (in_valid) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                model(is_signed, dividend, divisor, m_q, m_r, m_z);
            end
        end else begin
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            chk("out_valid_timing", 64'(out_valid), 64'(cyc - m_acc >= c_W + 2));
            if (out_valid) begin
                chk("quotient", 64'(quotient), 64'(m_q));
                chk("remainder", 64'(remainder), 64'(m_r));
                chk("div_by_zero", 64'(div_by_zero), 64'(m_z));
                if (out_ready) m_busy = 1'b0;
            end
        end
    end

    task automatic do_req(input bit s, input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        // Scribble on the inputs while busy; they must be ignored.
        in_valid  = $urandom_range(0, 1);
        is_signed = $urandom_range(0, 1);
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Waits for the result, optionally stalling it randomly; lat counts cycles
    // from the request-presenting cycle to the first out_valid cycle.
    task automatic get_res(input bit bp, output logic [c_W-1:0] q, output logic [c_W-1:0] r,
                           output logic z, output int lat);
        int  n = 1;
        bit  seen = 1'b0;
        bit  got = 1'b0;
        lat = -1; q = '0; r = '0; z = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk); #1; n++;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1; lat = n; q = quotient; r = remainder; z = div_by_zero;
                end
                out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    @(posedge clk); #1;
                    out_ready = 1'b0;
                    in_valid  = 1'b0;
                    got = 1'b1;
                end
            end
        end
        if (!got) chk("result_timeout", 64'(got), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input bit s, input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                       input logic [c_W-1:0] eq, input logic [c_W-1:0] er, input logic ez);
        logic [c_W-1:0] q, r;
        logic z;
        int lat;
        do_req(s, a, b);
        get_res(1'b0, q, r, z, lat);
        chk({name, "_q"}, 64'(q), 64'(eq));
        chk({name, "_r"}, 64'(r), 64'(er));
        chk({name, "_z"}, 64'(z), 64'(ez));
    endtask

    initial begin
        logic [c_W-1:0] q, r, hq, hr;
        logic z, hz;
        int lat;
        logic [c_W-1:0] a, b;
        bit s;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);

        do_req(1'b0, 32'd100, 32'd7);
        get_res(1'b0, q, r, z, lat);
        chk("u100_7_q", 64'(q), 64'd14);
        chk("u100_7_r", 64'(r), 64'd2);
        chk("u100_7_latency", 64'(lat), 64'd34);

        lit("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        lit("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        lit("u_dbz", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        lit("s_dbz", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        lit("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        lit("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // Backpressure: hold the result for 10 cycles.
        do_req(1'b1, 32'hFFFF_FF9C, 32'd9);
        while (!out_valid && cyc < 5000) begin
            @(posedge clk); #1;
        end
        hq = quotient; hr = remainder; hz = div_by_zero;
        chk("bp_q", 64'(hq), 64'hFFFF_FFF5);
        chk("bp_r", 64'(hr), 64'hFFFF_FFFF);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_q", 64'(quotient), 64'(hq));
            chk("bp_hold_r", 64'(remainder), 64'(hr));
            chk("bp_hold_z", 64'(div_by_zero), 64'(hz));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);

        // Reset while the step counter is at 10.
        do_req(1'b0, 32'd1000, 32'd3);
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        lit("post_abort", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);

        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                4: begin a = 32'($urandom_range(0, 20)); b = $urandom; end
                default: b = $urandom;
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_req(s, a, b);
            get_res(1'b1, q, r, z, lat);
            chk("rand_latency", 64'(lat), 64'd34);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request presented.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with request.
REQ-007 SHALL have port dividend  input  WIDTH  numerator; sampled with request.
REQ-008 SHALL have port divisor  input  WIDTH  denominator; sampled with request.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  WIDTH  result quotient.
REQ-012 SHALL have port remainder  output  WIDTH  result remainder.
REQ-013 SHALL have port div_by_zero  output  1  flag, valid with out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; request accepted on edge where in_valid & in_ready.
REQ-016 SHALL on acceptance latch is_signed, operands as magnitudes (abs value if is_signed and MSB set), result signs, enter CALC.
REQ-017 SHALL in CALC perform one restoring shift-subtract step per cycle, exactly WIDTH cycles, via step counter WIDTH-1 down to 0.
REQ-018 SHALL after final step go to FIX for one cycle applying sign correction: quotient negated if signs of operands differ, remainder negated if dividend negative (signed mode only).
REQ-019 SHALL enter DONE after FIX; out_valid=1 only in DONE; total latency acceptance edge to out_valid = WIDTH+2 cycles, independent of operand values.
REQ-020 SHALL hold quotient, remainder, div_by_zero stable while out_valid & !out_ready.
REQ-021 SHALL return to IDLE on edge where out_valid & out_ready; in_ready rises next cycle (no same-cycle accept of new request).
REQ-022 SHALL for divisor==0: quotient = all ones, remainder = original dividend, div_by_zero=1, both modes, same latency.
REQ-023 SHALL for signed overflow (dividend = most-negative, divisor = -1): quotient = most-negative, remainder = 0, div_by_zero=0.
REQ-024 SHALL satisfy, for all other inputs, dividend == quotient*divisor + remainder, |remainder| < |divisor|, truncation toward zero.
REQ-025 SHALL ignore in_valid and operand changes outside IDLE.
REQ-026 SHALL compute most-negative magnitude correctly (WIDTH+1-bit intermediate or unsigned reinterpretation), no wrap error.

Reset
REQ-027 SHALL on reset=1 at any edge, in any state including CALC/DONE, enter IDLE, abort in-flight operation, discard result.
REQ-028 SHALL reset values: in_ready=1 after reset deasserts, out_valid=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
REQ-029 SHALL give reset priority over acceptance and out_ready handshake on same edge.

Verification
REQ-030 SHALL cover unsigned 100/7 (WIDTH=32) -> quotient=14, remainder=2, out_valid exactly 34 cycles after accept.
REQ-031 SHALL cover signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-032 SHALL cover divide by zero, dividend=0x12345678, both modes -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
REQ-033 SHALL cover signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-034 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover reset asserted at CALC step 10 -> next cycle IDLE, out_valid=0, in_ready=1; following request 0xFFFFFFFF/0x10 unsigned -> quotient=0x0FFFFFFF, remainder=0xF.
